// File: rtl/epu_pkg.sv
// Shared types and sizing for the EPU input loader: FSM states, beat/word
// geometry and input-SRAM address width.
package epu_pkg;
    localparam int BEATS_PER_WORD = 4;
    localparam int ADDR_W         = 12;
    localparam int BEAT_W         = 32;
    localparam int WORD_W         = BEAT_W * BEATS_PER_WORD;
    localparam int WEB_W          = WORD_W / 8;
    localparam int COUNT_W        = ADDR_W + 1;
    localparam int LANE_W         = $clog2(BEATS_PER_WORD);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_KICK = 2'd2,
        ST_WAIT = 2'd3
    } epu_state_e;
endpackage

// File: rtl/epu_in_loader_if.sv
// 32-bit source stream into the loader. A beat moves on a rising edge when
// in_valid && in_ready; the source holds data/last steady while in_valid waits.
interface epu_in_loader_if;
    import epu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [BEAT_W-1:0] in_data;
    logic              in_last;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/epu_word_packer.sv
// Packs four 32-bit beats little-endian into one 128-bit word; full pulses
// for the single cycle after the fourth beat while word holds the result.
module epu_word_packer
    import epu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              accept,
    input  logic [BEAT_W-1:0] data,
    output logic              beat_last,
    output logic              full,
    output logic [WORD_W-1:0] word
);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BEATS_PER_WORD - 1);

    logic [LANE_W-1:0]        lane_cnt;
    logic [WORD_W-BEAT_W-1:0] lanes;

    assign beat_last = accept && (lane_cnt == LAST_LANE);

    // The top lane bypasses the lane register so the next group can start
    // filling on the very next beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_cnt <= '0;
            lanes    <= '0;
            full     <= 1'b0;
            word     <= '0;
        end else begin
            full <= beat_last;
            if (beat_last) begin
                word     <= {data, lanes};
                lane_cnt <= '0;
            end else if (accept) begin
                lanes[int'(lane_cnt)*BEAT_W +: BEAT_W] <= data;
                lane_cnt <= lane_cnt + LANE_W'(1);
            end
        end
    end
endmodule

// File: rtl/epu_in_loader.sv
// Loads cfg_words 128-bit words from a 32-bit stream into the input SRAM,
// then raises start to the EPU and waits for its end_signal.
module epu_in_loader
    import epu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_start,
    input  logic [ADDR_W-1:0]  cfg_base,
    input  logic [COUNT_W-1:0] cfg_words,
    epu_in_loader_if.slave     src,
    output logic [ADDR_W-1:0]  A_s7,
    output logic [WEB_W-1:0]   WEB_s7,
    output logic [WORD_W-1:0]  DI_s7,
    output logic               start_signal_s7,
    input  logic               end_signal,
    output logic               busy,
    output logic               done,
    output logic               err,
    output epu_state_e         state_dbg
);
    epu_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [COUNT_W-1:0] words_left_q;
    logic               accept, beat_last, full, final_beat;

    assign src.in_ready    = (state_q == ST_LOAD) && (words_left_q != '0);
    assign accept          = src.in_valid && src.in_ready;
    assign final_beat      = beat_last && (words_left_q == COUNT_W'(1));
    assign busy            = (state_q != ST_IDLE);
    assign start_signal_s7 = (state_q == ST_KICK) || (state_q == ST_WAIT);
    assign state_dbg       = state_q;
    // Gating with rst drops a write that was already queued when reset arrives.
    assign WEB_s7          = (full && !rst) ? '0 : '1;

    epu_word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .accept    (accept),
        .data      (src.in_data),
        .beat_last (beat_last),
        .full      (full),
        .word      (DI_s7)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cfg_start && (cfg_words != '0)) state_d = ST_LOAD;
            ST_LOAD: if (full && (words_left_q == '0))   state_d = ST_KICK;
            ST_KICK: state_d = ST_WAIT;
            ST_WAIT: if (end_signal)                     state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            words_left_q <= '0;
            A_s7         <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= 1'b0;
            if ((state_q == ST_IDLE) && cfg_start) begin
                err <= 1'b0;
                if (cfg_words != '0) begin
                    addr_q       <= cfg_base;
                    words_left_q <= cfg_words;
                end else begin
                    done <= 1'b1;
                end
            end
            // A_s7 is captured with the word so it is valid during the strobe
            // and keeps the last written address afterwards.
            if (beat_last) begin
                A_s7         <= addr_q;
                addr_q       <= addr_q + ADDR_W'(1);
                words_left_q <= words_left_q - COUNT_W'(1);
            end
            if (accept && (src.in_last != final_beat)) err <= 1'b1;
            if ((state_q == ST_WAIT) && end_signal) done <= 1'b1;
        end
    end
endmodule

// File: tb/tb_epu_in_loader.sv
// Bench for epu_in_loader: vector table plus random loads checked against a
// word/address model, and hand sequences for reset-mid-load and empty loads.
module tb_epu_in_loader;
    import epu_pkg::*;

    typedef struct {
        logic [ADDR_W-1:0] base;
        int                words;
        int                vmode;     // 0 continuous, 1 toggling, 2 random valid
        int                last_at;   // 1-based beat carrying in_last, 0 = none
        bit                seq_data;
        bit                poke;      // cfg_start pulsed during LOAD
        int                end_delay;
        bit                exp_err;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_start;
    logic [ADDR_W-1:0]  cfg_base;
    logic [COUNT_W-1:0] cfg_words;
    logic [ADDR_W-1:0]  A_s7;
    logic [WEB_W-1:0]   WEB_s7;
    logic [WORD_W-1:0]  DI_s7;
    logic               start_signal_s7;
    logic               end_signal;
    logic               busy;
    logic               done;
    logic               err;
    epu_state_e         state_dbg;

    epu_in_loader_if src_if();

    always #5 clk = ~clk;

    epu_in_loader dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_start       (cfg_start),
        .cfg_base        (cfg_base),
        .cfg_words       (cfg_words),
        .src             (src_if),
        .A_s7            (A_s7),
        .WEB_s7          (WEB_s7),
        .DI_s7           (DI_s7),
        .start_signal_s7 (start_signal_s7),
        .end_signal      (end_signal),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .state_dbg       (state_dbg)
    );

    int checks = 0;
    int errors = 0;
    logic [ADDR_W+WORD_W-1:0] exp_q[$];
    logic [ADDR_W+WORD_W-1:0] mon_exp;
    vec_t vecs[12];

    task automatic check(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every strobe must be a full-word write matching the next expected word.
    always @(negedge clk) begin
        if (WEB_s7 !== '1) begin
            checks++;
            if (WEB_s7 !== '0 || exp_q.size() == 0) begin
                errors++;
                $display("FAIL sram_write: got A=%0h WEB=%0h DI=%0h with no full write expected", A_s7, WEB_s7, DI_s7);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({A_s7, DI_s7} !== mon_exp) begin
                    errors++;
                    $display("FAIL sram_write: got A=%0h DI=%0h expected A=%0h DI=%0h",
                             A_s7, DI_s7, mon_exp[WORD_W +: ADDR_W], mon_exp[WORD_W-1:0]);
                end
            end
        end
    end

    function automatic vec_t mk(input logic [ADDR_W-1:0] base, input int words, input int vmode,
                                input int last_at, input bit seq_data, input bit poke,
                                input int end_delay, input bit exp_err);
        vec_t v;
        v.base = base; v.words = words; v.vmode = vmode; v.last_at = last_at;
        v.seq_data = seq_data; v.poke = poke; v.end_delay = end_delay; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic run_load(input vec_t v);
        logic [BEAT_W-1:0] beats[$];
        logic [WORD_W-1:0] w, last_w;
        logic [ADDR_W-1:0] a, last_a;
        int  n, guard;
        bit  acc, v_now, tog;
        n = BEATS_PER_WORD * v.words;
        last_w = '0;
        last_a = '0;
        for (int k = 0; k < n; k++) beats.push_back(v.seq_data ? BEAT_W'(k + 1) : $urandom);
        for (int wi = 0; wi < v.words; wi++) begin
            w = '0;
            for (int k = 0; k < BEATS_PER_WORD; k++)
                w = w | (WORD_W'(beats[BEATS_PER_WORD*wi + k]) << (BEAT_W*k));
            a = ADDR_W'((int'(v.base) + wi) % 4096);
            exp_q.push_back({a, w});
            last_a = a;
            last_w = w;
        end

        end_signal = 1'b1;
        @(posedge clk); #1;
        end_signal = 1'b0;
        @(negedge clk);
        check("idle_end_done", done, 0);
        check("idle_end_busy", busy, 0);
        @(posedge clk); #1;

        cfg_base  = v.base;
        cfg_words = COUNT_W'(v.words);
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        @(negedge clk);
        check("load_busy", busy, 1);
        check("load_ready", src_if.in_ready, 1);
        @(posedge clk); #1;

        tog = 1'b1;
        for (int i = 0; i < n; i++) begin
            acc = 1'b0;
            guard = 0;
            while (!acc && guard < 100) begin
                case (v.vmode)
                    0:       v_now = 1'b1;
                    1:       v_now = tog;
                    default: v_now = 1'($urandom_range(0, 1));
                endcase
                tog = !tog;
                cfg_start = v.poke && (i == 1);
                cfg_base  = cfg_start ? (v.base ^ 12'h5A5) : v.base;
                src_if.in_valid = v_now;
                src_if.in_data  = v_now ? beats[i] : 32'hDEAD_BEEF;
                src_if.in_last  = v_now && (i + 1 == v.last_at);
                @(negedge clk);
                acc = v_now && src_if.in_ready;
                @(posedge clk); #1;
                guard++;
            end
            check("beat_accept", acc, 1);
        end
        src_if.in_valid = 1'b0;
        src_if.in_last  = 1'b0;
        cfg_start = 1'b0;
        cfg_base  = v.base;

        guard = 0;
        @(negedge clk);
        while (start_signal_s7 !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("start_rise", start_signal_s7, 1);
        check("kick_state", state_dbg, ST_KICK);
        check("writes_done", exp_q.size(), 0);
        exp_q.delete();
        check("err_flag", err, v.exp_err);
        check("ready_after_load", src_if.in_ready, 0);
        check("addr_hold", A_s7, last_a);
        check("data_hold", DI_s7, last_w);

        repeat (v.end_delay) @(negedge clk);
        check("start_hold", start_signal_s7, 1);
        check("wait_state", state_dbg, ST_WAIT);
        check("wait_busy", busy, 1);

        @(posedge clk); #1;
        end_signal = 1'b1;
        @(posedge clk); #1;
        end_signal = 1'b0;
        @(negedge clk);
        check("end_done", done, 1);
        check("end_start_drop", start_signal_s7, 0);
        check("end_idle_busy", busy, 0);
        @(negedge clk);
        check("done_pulse_len", done, 0);
        check("err_sticky", err, v.exp_err);
        @(posedge clk); #1;
    endtask

    task automatic reset_mid_load();
        cfg_base  = 12'd5;
        cfg_words = 13'd2;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        for (int k = 0; k < BEATS_PER_WORD; k++) begin
            src_if.in_valid = 1'b1;
            src_if.in_data  = $urandom;
            src_if.in_last  = (k == 1);
            @(posedge clk); #1;
        end
        src_if.in_valid = 1'b0;
        src_if.in_last  = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_web_suppressed", WEB_s7, 16'hFFFF);
        check("err_before_rst", err, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_web", WEB_s7, 16'hFFFF);
        check("rst_addr", A_s7, 0);
        check("rst_data", DI_s7, 0);
        check("rst_start", start_signal_s7, 0);
        check("rst_ready", src_if.in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_state", state_dbg, ST_IDLE);
        @(negedge clk);
        check("after_rst_web", WEB_s7, 16'hFFFF);
        @(posedge clk); #1;
    endtask

    task automatic zero_words();
        cfg_base  = 12'd9;
        cfg_words = 13'd0;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        @(negedge clk);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_start", start_signal_s7, 0);
        @(negedge clk);
        check("zero_done_len", done, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("zero_no_start", start_signal_s7, 0);
            check("zero_idle", state_dbg, ST_IDLE);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        cfg_start = 1'b0;
        cfg_base = '0;
        cfg_words = '0;
        end_signal = 1'b0;
        src_if.in_valid = 1'b0;
        src_if.in_data = '0;
        src_if.in_last = 1'b0;

        vecs[0] = mk(12'd0,    2, 0, 8, 1'b1, 1'b0, 3,  1'b0);
        vecs[1] = mk(12'd4095, 2, 0, 8, 1'b0, 1'b0, 2,  1'b0);
        vecs[2] = mk(12'd100,  1, 1, 4, 1'b0, 1'b0, 2,  1'b0);
        vecs[3] = mk(12'd7,    1, 0, 3, 1'b0, 1'b0, 2,  1'b1);
        vecs[4] = mk(12'd50,   2, 0, 8, 1'b0, 1'b1, 10, 1'b0);
        vecs[5] = mk(12'd200,  2, 0, 0, 1'b0, 1'b0, 1,  1'b1);
        for (int i = 6; i < 12; i++) begin
            int words, last_at;
            words   = $urandom_range(1, 5);
            last_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4*words) : 4*words;
            vecs[i] = mk(ADDR_W'($urandom_range(0, 4095)), words, 2, last_at, 1'b0, 1'b0,
                         $urandom_range(1, 5), last_at != 4*words);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_web", WEB_s7, 16'hFFFF);
        check("reset_addr", A_s7, 0);
        check("reset_data", DI_s7, 0);
        check("reset_start", start_signal_s7, 0);
        check("reset_ready", src_if.in_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        check("reset_state", state_dbg, ST_IDLE);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_load(vecs[i]);
        reset_mid_load();
        zero_words();
        run_load(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/epu_in_loader.md
EPU_IN_LOADER -- requirements
Module: epu_in_loader

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port cfg_start, input, 1: one-cycle load request; sampled only in IDLE.
REQ-004 SHALL have port cfg_base, input, 12: first input-SRAM word address.
REQ-005 SHALL have port cfg_words, input, 13: number of 128-bit words to load, 0..4096.
REQ-006 SHALL have port in_valid / in_ready / in_data[31:0] / in_last, input/output/input/input: 32-bit valid-ready source stream; beat transfers when in_valid & in_ready.
REQ-007 SHALL have ports A_s7 (output, 12), WEB_s7 (output, 16, active-low byte write enables) and DI_s7 (output, 128): input-SRAM write port.
REQ-008 SHALL have port start_signal_s7, output, 1: level start to EPU.
REQ-009 SHALL have port end_signal, input, 1: EPU completion.
REQ-010 SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse) and err (output, 1, sticky until next cfg_start).

Function
REQ-011 SHALL implement FSM IDLE -> LOAD -> KICK -> WAIT -> IDLE.
REQ-012 IDLE: cfg_start with cfg_words>0 SHALL latch base/count, clear err, enter LOAD next cycle; cfg_words==0 SHALL pulse done next cycle, stay IDLE, never assert start.
REQ-013 LOAD: in_ready SHALL be 1; accepted beats pack little-endian, beat k of a group into DI bits [32k+31:32k], k=0..3.
REQ-014 On the 4th accepted beat of a group, the following cycle SHALL present WEB_s7=16'h0000, A_s7=current address, DI_s7=packed word for exactly one cycle.
REQ-015 Packing register SHALL be freed on the 4th beat so back-to-back beats sustain one 128-bit write every 4 cycles without stall.
REQ-016 Address SHALL increment by 1 per write, wrapping 4095 -> 0.
REQ-017 After the cfg_words-th write, FSM SHALL enter KICK; in_ready SHALL be 0 outside LOAD.
REQ-018 in_last SHALL be expected only on the final beat (beat 4*cfg_words); in_last on any other beat, or its absence on the final beat, SHALL set err; loading continues to count regardless.
REQ-019 KICK: start_signal_s7 SHALL rise and hold high through WAIT.
REQ-020 WAIT: end_signal high SHALL drop start_signal_s7 and pulse done in the same next cycle, return to IDLE; end_signal outside WAIT SHALL be ignored.
REQ-021 cfg_start outside IDLE SHALL be ignored.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 When not writing, WEB_s7 SHALL be 16'hFFFF; A_s7/DI_s7 SHALL hold last values.

Reset
REQ-024 rst SHALL force IDLE, WEB_s7=16'hFFFF, A_s7=0, DI_s7=0, start_signal_s7=0, in_ready=0, busy=0, done=0, err=0, clear pack state and counters.
REQ-025 rst mid-LOAD SHALL suppress any pending write; no write strobe in the cycle after rst.

Structure
REQ-026 FSM state enum, beats-per-word (4), SRAM address width (12) and data widths SHALL live in shared package epu_pkg.
REQ-027 32->128 packer (beat counter, lane register, full flag) SHALL be sub-module epu_word_packer; FSM and address counter stay in top.

Verification
REQ-028 cfg_base=0, cfg_words=2, beats 0x00000001..0x00000008 continuous, in_last on beat 8 -> writes A=0 DI=0x00000004_00000003_00000002_00000001, A=1 DI=0x...08_07_06_05; start rises; err=0.
REQ-029 cfg_base=4095, cfg_words=2 -> writes at A=4095 then A=0.
REQ-030 in_valid toggled 1/0 every cycle, cfg_words=1 -> single write after 4th accepted beat, DI correct, no extra WEB pulses.
REQ-031 in_last on beat 3 of cfg_words=1 -> err=1, write still issued after beat 4, done after end_signal.
REQ-032 end_signal pulsed at IDLE, then in WAIT after 10 cycles -> first ignored; second drops start, one-cycle done; cfg_start during LOAD ignored.
REQ-033 rst asserted cycle after 4th beat -> no write strobe, all outputs at reset values; cfg_words=0 -> done pulse, start never asserted.
